if_fetch: RTL and testbench

- Instruction-fetch stage; the producer side of the IF→IF/ID interface.
- Holds the PC and fetches each 32-bit instruction as four byte reads over the byte-wide memory-controller port.
- Presents if_pc/if_inst to the IF/ID register and raises stallreq_if to ctrl while a fetch is incomplete.
- Honours ctrl's stall vector and redirects on taken branches/jumps from EX.

---
 rtl/if_fetch_pkg.sv | 16 +
 rtl/if_icache.sv | 39 +++
 rtl/if_fetch.sv | 84 ++++++++
 tb/tb_if_fetch.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared constants, bus types and IF state encodings for the fetch stage.
package if_fetch_pkg;
  localparam logic RstEnable = 1'b1;
  localparam logic Stop = 1'b1;
  localparam logic NoStop = 1'b0;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;
  localparam int StallW = 6;
  typedef logic [31:0] inst_addr_t;
  typedef logic [31:0] inst_t;
  typedef logic [StallW-1:0] stall_t;
  localparam logic [0:0] S_FETCH = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;
  function automatic int icache_index_w(input int entries);
    return $clog2(entries);
  endfunction
endpackage

// File: rtl/if_icache.sv
// if_icache: direct-mapped one-word-per-line instruction cache (lookup and fill).
module if_icache
  import if_fetch_pkg::*;
#(
  parameter int ENTRIES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  inst_addr_t lookup_pc,
  input  logic       fill_en,
  input  inst_addr_t fill_pc,
  input  inst_t      fill_data,
  output logic       hit,
  output inst_t      data
);
  localparam int IW = icache_index_w(ENTRIES);
  localparam int TW = 30 - IW;
  logic [ENTRIES-1:0] valid;
  logic [TW-1:0] tags [ENTRIES];
  inst_t words [ENTRIES];
  logic [IW-1:0] lidx, fidx;
  logic unused_pc;
  assign lidx = lookup_pc[IW+1:2];
  assign fidx = fill_pc[IW+1:2];
  assign hit = valid[lidx] && tags[lidx] == lookup_pc[31:IW+2];
  assign data = words[lidx];
  assign unused_pc = ^{lookup_pc[1:0], fill_pc[1:0]};
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) valid <= '0;
    else if (fill_en) valid[fidx] <= 1'b1;
  end
  // Tag/data storage carries no reset; the valid bits alone qualify it.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tags[fidx] <= fill_pc[31:IW+2];
      words[fidx] <= fill_data;
    end
  end
endmodule

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage assembling 32-bit words from four byte reads.
// Optional direct-mapped icache enabled by defining ICACHE_EN.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int ICACHE_ENTRIES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  stall_t     stall,
  input  logic       branch_flag_i,
  input  inst_addr_t branch_target_i,
  input  logic       mem_if_valid,
  input  logic [7:0] mem_if_data,
  output logic       if_mem_req,
  output inst_addr_t if_mem_addr,
  output inst_addr_t if_pc,
  output inst_t      if_inst,
  output logic       stallreq_if
);
  logic [0:0] state;
  inst_addr_t pc;
  inst_t inst_buf, hit_data;
  logic [1:0] byte_cnt;
  logic hit, take, last;
  logic unused_bits;
`ifdef ICACHE_EN
  logic line_hit, fill_en;
  assign fill_en = take && last && !branch_flag_i;
  if_icache #(.ENTRIES(ICACHE_ENTRIES)) u_icache (
    .clk(clk),
    .rst(rst),
    .lookup_pc(pc),
    .fill_en(fill_en),
    .fill_pc(pc),
    .fill_data({mem_if_data, inst_buf[23:0]}),
    .hit(line_hit),
    .data(hit_data)
  );
  // Lookup only counts on entry to a fetch, before any byte has been taken.
  assign hit = line_hit && state == S_FETCH && byte_cnt == 2'd0;
`else
  assign hit = 1'b0;
  assign hit_data = ZeroWord;
`endif
  assign if_mem_req = !rst && state == S_FETCH && !hit;
  assign if_mem_addr = rst ? ZeroWord : pc + {30'd0, byte_cnt};
  assign stallreq_if = rst || state == S_FETCH;
  assign take = if_mem_req && mem_if_valid;
  assign last = byte_cnt == 2'd3;
  assign unused_bits = ^{stall[5:2], stall[0], branch_target_i[1:0], inst_buf[31:24]};
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state <= S_FETCH;
      pc <= RESET_PC;
      byte_cnt <= 2'd0;
      inst_buf <= ZeroWord;
      if_pc <= ZeroWord;
      if_inst <= ZeroWord;
    end else if (branch_flag_i) begin
      pc <= {branch_target_i[31:2], 2'b00};
      byte_cnt <= 2'd0;
      state <= S_FETCH;
    end else if (state == S_FETCH) begin
      if (hit) begin
        if_inst <= hit_data;
        if_pc <= pc;
        state <= S_HOLD;
      end else if (take) begin
        inst_buf[{byte_cnt, 3'b000} +: 8] <= mem_if_data;
        byte_cnt <= byte_cnt + 2'd1;
        if (last) begin
          if_inst <= {mem_if_data, inst_buf[23:0]};
          if_pc <= pc;
          state <= S_HOLD;
        end
      end
    end else if (stall[1] == NoStop) begin
      pc <= pc + 32'd4;
      state <= S_FETCH;
    end
  end
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: table-driven check of if_fetch plus hand-written reset, wrap and icache sequences.
module tb_if_fetch;
  logic clk = 1'b0, rst = 1'b1;
  logic [5:0] stall = 6'd0, w_stall = 6'h3f;
  logic branch = 1'b0, valid = 1'b0, w_valid = 1'b0;
  logic [31:0] target = 32'd0;
  logic [7:0] data = 8'd0, w_data = 8'd0;
  logic req, sreq, w_req, w_sreq;
  logic [31:0] addr, pc, inst, w_addr, w_pc, w_inst;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  if_fetch dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_flag_i(branch), .branch_target_i(target),
    .mem_if_valid(valid), .mem_if_data(data), .if_mem_req(req), .if_mem_addr(addr),
    .if_pc(pc), .if_inst(inst), .stallreq_if(sreq)
  );

  if_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst), .stall(w_stall), .branch_flag_i(1'b0), .branch_target_i(32'd0),
    .mem_if_valid(w_valid), .mem_if_data(w_data), .if_mem_req(w_req), .if_mem_addr(w_addr),
    .if_pc(w_pc), .if_inst(w_inst), .stallreq_if(w_sreq)
  );

  typedef struct {
    logic s1, br;
    logic [31:0] tgt;
    logic v;
    logic [7:0] d;
    logic req, sreq;
    logic [31:0] addr, pc, inst;
  } vec_t;
  vec_t vt [26];

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  initial begin
    // s1 br tgt v d | req sreq addr pc inst
    vt[0]  = '{1'b0, 1'b0, 32'h0, 1'b1, 8'h13, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0};
    vt[1]  = '{1'b0, 1'b0, 32'h0, 1'b1, 8'h00, 1'b1, 1'b1, 32'h1, 32'h0, 32'h0};
    vt[2]  = '{1'b0, 1'b0, 32'h0, 1'b1, 8'h00, 1'b1, 1'b1, 32'h2, 32'h0, 32'h0};
    vt[3]  = '{1'b0, 1'b0, 32'h0, 1'b1, 8'h00, 1'b1, 1'b1, 32'h3, 32'h0, 32'h0};
    for (int i = 4; i < 9; i++)
      vt[i] = '{1'b1, 1'b0, 32'h0, 1'b1, 8'hFF, 1'b0, 1'b0, 32'h0, 32'h0, 32'h13};
    vt[9]  = '{1'b0, 1'b0, 32'h0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 32'h0, 32'h13};
    vt[10] = '{1'b0, 1'b0, 32'h0, 1'b1, 8'h93, 1'b1, 1'b1, 32'h4, 32'h0, 32'h13};
    vt[11] = '{1'b0, 1'b0, 32'h0, 1'b0, 8'h00, 1'b1, 1'b1, 32'h5, 32'h0, 32'h13};
    vt[12] = '{1'b0, 1'b0, 32'h0, 1'b1, 8'h00, 1'b1, 1'b1, 32'h5, 32'h0, 32'h13};
    vt[13] = '{1'b0, 1'b0, 32'h0, 1'b1, 8'h10, 1'b1, 1'b1, 32'h6, 32'h0, 32'h13};
    vt[14] = '{1'b1, 1'b0, 32'h0, 1'b1, 8'h00, 1'b1, 1'b1, 32'h7, 32'h0, 32'h13};
    vt[15] = '{1'b0, 1'b0, 32'h0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 32'h4, 32'h0010_0093};
    vt[16] = '{1'b0, 1'b0, 32'h0, 1'b1, 8'hAA, 1'b1, 1'b1, 32'h8, 32'h4, 32'h0010_0093};
    vt[17] = '{1'b0, 1'b0, 32'h0, 1'b1, 8'hBB, 1'b1, 1'b1, 32'h9, 32'h4, 32'h0010_0093};
    vt[18] = '{1'b0, 1'b1, 32'h1006, 1'b1, 8'hCC, 1'b1, 1'b1, 32'hA, 32'h4, 32'h0010_0093};
    vt[19] = '{1'b0, 1'b0, 32'h0, 1'b1, 8'hB7, 1'b1, 1'b1, 32'h1004, 32'h4, 32'h0010_0093};
    vt[20] = '{1'b0, 1'b0, 32'h0, 1'b1, 8'h02, 1'b1, 1'b1, 32'h1005, 32'h4, 32'h0010_0093};
    vt[21] = '{1'b0, 1'b0, 32'h0, 1'b1, 8'h00, 1'b1, 1'b1, 32'h1006, 32'h4, 32'h0010_0093};
    vt[22] = '{1'b0, 1'b0, 32'h0, 1'b1, 8'h00, 1'b1, 1'b1, 32'h1007, 32'h4, 32'h0010_0093};
    vt[23] = '{1'b1, 1'b0, 32'h0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 32'h1004, 32'h2B7};
    vt[24] = '{1'b1, 1'b1, 32'h2000, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 32'h1004, 32'h2B7};
    vt[25] = '{1'b0, 1'b0, 32'h0, 1'b0, 8'h00, 1'b1, 1'b1, 32'h2000, 32'h1004, 32'h2B7};

    #2;
    chk("rst_req", -1, req, 1'b0);
    chk("rst_addr", -1, addr, 32'h0);
    chk("rst_pc", -1, pc, 32'h0);
    chk("rst_inst", -1, inst, 32'h0);
    chk("rst_stallreq", -1, sreq, 1'b1);
    @(negedge clk);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      stall = {4'd0, vt[i].s1, 1'b0};
      branch = vt[i].br;
      target = vt[i].tgt;
      valid = vt[i].v;
      data = vt[i].d;
      #1;
      chk("req", i, req, vt[i].req);
      chk("stallreq", i, sreq, vt[i].sreq);
      if (vt[i].req) chk("addr", i, addr, vt[i].addr);
      chk("pc", i, pc, vt[i].pc);
      chk("inst", i, inst, vt[i].inst);
    end

    // Asynchronous reset between edges with one byte already taken.
    @(negedge clk);
    stall = 6'd0; branch = 1'b0; valid = 1'b1; data = 8'h11;
    #1 chk("ar_addr0", 0, addr, 32'h2000);
    @(negedge clk) valid = 1'b0;
    #1 chk("ar_addr1", 1, addr, 32'h2001);
    #2 rst = 1'b1;
    #1;
    chk("ar_req", 2, req, 1'b0);
    chk("ar_addr", 2, addr, 32'h0);
    chk("ar_pc", 2, pc, 32'h0);
    chk("ar_inst", 2, inst, 32'h0);
    chk("ar_stallreq", 2, sreq, 1'b1);
    @(negedge clk) rst = 1'b0;
    #1;
    chk("ar_restart_req", 3, req, 1'b1);
    chk("ar_restart_addr", 3, addr, 32'h0);
    chk("w_restart_addr", 3, w_addr, 32'hFFFF_FFFC);

    // PC wrap: fetch at 0xFFFF_FFFC, then next fetch starts at 0.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      w_valid = 1'b1;
      w_data = 8'h78 - 8'(i * 8'h22);
      #1 chk("w_addr", i, w_addr, 32'hFFFF_FFFC + 32'(i));
    end
    @(negedge clk) begin w_valid = 1'b0; w_stall = 6'd0; end
    #1;
    chk("w_pc", 4, w_pc, 32'hFFFF_FFFC);
    chk("w_inst", 4, w_inst, 32'h1234_5678);
    chk("w_req", 4, w_req, 1'b0);
    chk("w_stallreq", 4, w_sreq, 1'b0);
    @(negedge clk) w_stall = 6'h3f;
    #1;
    chk("w_wrap_req", 5, w_req, 1'b1);
    chk("w_wrap_addr", 5, w_addr, 32'h0);

`ifdef ICACHE_EN
    // Fill line for 0x40, jump back to it, expect a hit with 2-cycle turnaround.
    @(negedge clk) begin branch = 1'b1; target = 32'h40; end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      branch = 1'b0;
      valid = 1'b1;
      data = (i == 0) ? 8'hEF : (i == 1) ? 8'hBE : (i == 2) ? 8'hAD : 8'hDE;
      #1 chk("ic_fill_addr", i, addr, 32'h40 + 32'(i));
    end
    @(negedge clk) begin valid = 1'b0; branch = 1'b1; target = 32'h40; end
    #1 chk("ic_fill_inst", 4, inst, 32'hDEAD_BEEF);
    @(negedge clk) branch = 1'b0;
    #1;
    chk("ic_hit_req", 5, req, 1'b0);
    chk("ic_hit_stallreq", 5, sreq, 1'b1);
    @(negedge clk) stall = 6'h02;
    #1;
    chk("ic_hold_stallreq", 6, sreq, 1'b0);
    chk("ic_hold_pc", 6, pc, 32'h40);
    chk("ic_hold_inst", 6, inst, 32'hDEAD_BEEF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
